hb_monitor: RTL and testbench
=============================

HB_MONITOR -- requirements
Module: hb_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent session channels (1..16).
REQ-002 SHALL have parameter HB_RANGE, default 16: interval counter width in bits.
REQ-003 SHALL have parameter DEFAULT_INTERVAL, default 100: reset value of every channel interval.
REQ-004 SHALL have port clk  in  1  clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset: synchronous, active-high.
REQ-006 SHALL have port start_i  in  NUM_CH  per-channel arm request.
REQ-007 SHALL have port stop_i  in  NUM_CH  per-channel disarm request.
REQ-008 SHALL have port msg_rx_i  in  NUM_CH  per-channel inbound-message strobe.
REQ-009 SHALL have port cfg_we_i  in  1  interval write strobe.
REQ-010 SHALL have port cfg_ch_i  in  clog2(NUM_CH), minimum 1  channel index for cfg write.
REQ-011 SHALL have port cfg_interval_i  in  HB_RANGE  new interval value.
REQ-012 SHALL have port active_o  out  NUM_CH  channel is armed (any state other than IDLE).
REQ-013 SHALL have port evt_valid_o  out  1  event available.
REQ-014 SHALL have port evt_ready_i  in  1  consumer accepts event.
REQ-015 SHALL have port evt_ch_o  out  clog2(NUM_CH), minimum 1  channel of the presented event.
REQ-016 SHALL have port evt_type_o  out  1  0=TEST_REQ, 1=TIMEOUT.
REQ-017 SHALL have port ovf_o  out  NUM_CH  sticky flag: a pending event was overwritten.

Function
REQ-018 SHALL keep, per channel, an FSM with states IDLE, ARMED, TESTREQ, a HB_RANGE-bit counter, an interval register and a pending-event flag+type.
REQ-019 SHALL, in IDLE, move to ARMED with count=0 on start_i when the interval is non-zero; start_i SHALL be ignored when the interval is 0.
REQ-020 SHALL, in ARMED or TESTREQ, increment count every cycle, reset count to 0 and return to ARMED on msg_rx_i, and re-arm (count=0, ARMED) on start_i.
REQ-021 SHALL detect expiry when count equals the interval with no msg_rx_i in that cycle; expiry is therefore detected interval+1 cycles after arming.
REQ-022 SHALL, on expiry in ARMED, enter TESTREQ with count=0 and post a TEST_REQ event.
REQ-023 SHALL, on expiry in TESTREQ, enter IDLE and post a TIMEOUT event.
REQ-024 SHALL apply priority stop_i > msg_rx_i > start_i > expiry; stop_i forces IDLE and clears that channel's pending event.
REQ-025 SHALL set the pending flag in the cycle after expiry; if a flag is already pending, the new type SHALL replace it and ovf_o[ch] SHALL set.
REQ-026 SHALL select among pending channels round-robin, searching from the last granted channel + 1.
REQ-027 SHALL hold evt_valid_o, evt_ch_o and evt_type_o stable until evt_ready_i is high; the pending flag SHALL clear on the handshake cycle.
REQ-028 SHALL apply a cfg write in the next cycle; a write to an armed channel SHALL affect the current comparison without resetting count; if the new interval is at or below the current count, expiry SHALL occur at counter wrap.
REQ-029 SHALL wrap the counter modulo 2^HB_RANGE.

Reset
REQ-030 SHALL, on rst, set all channels to IDLE with count=0, interval=DEFAULT_INTERVAL, no pending events, the round-robin pointer at 0, and all outputs 0.
REQ-031 SHALL let rst asserted mid-operation override every input in that cycle.

Configuration
REQ-032 SHALL, with macro HB_MON_TESTREQ_EN defined, implement the two-stage ARMED->TESTREQ->IDLE behaviour above.
REQ-033 SHALL, without HB_MON_TESTREQ_EN, omit TESTREQ; expiry in ARMED SHALL post TIMEOUT and go IDLE, and no TEST_REQ event SHALL ever occur.

Structure
REQ-034 SHALL take the state encoding, event-type encoding and the HB_RANGE default from shared package hb_pkg.
REQ-035 SHALL implement the arbiter as sub-module hb_rr_arb (NUM_CH requests, one-hot grant, pointer update on accept).

Verification
REQ-036 SHALL test: interval=5, start_i ch0 at cycle 0, no traffic -> TEST_REQ ch0 valid at cycle 7, TIMEOUT ch0 at cycle 13, then active_o[0]=0.
REQ-037 SHALL test: interval=5, msg_rx_i every 4 cycles -> no event for 100 cycles.
REQ-038 SHALL test: ch1 and ch2 expire in the same cycle, ready held low 3 cycles -> ch1 presented and stable, then ch2.
REQ-039 SHALL test: stop_i and msg_rx_i together with expiry -> IDLE, no event, no ovf.
REQ-040 SHALL test: ready low, ch0 posts TEST_REQ then TIMEOUT -> one TIMEOUT event, ovf_o[0]=1.
REQ-041 SHALL test: interval=0 with start_i -> stays IDLE; rst mid-count -> all outputs 0 next cycle.

Source files
------------

// File: rtl/hb_pkg.sv
// Shared types for the heartbeat monitor: channel state and event encodings,
// plus the channel-index width helper used by ports and the arbiter.
package hb_pkg;

    localparam int HB_RANGE_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_TESTREQ = 2'd2
    } hb_state_e;

    typedef enum logic {
        EVT_TEST_REQ = 1'b0,
        EVT_TIMEOUT  = 1'b1
    } hb_evt_e;

    // A single-channel build still needs a 1-bit index.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hb_monitor_if.sv
// Event handshake between the heartbeat monitor (master) and its consumer.
interface hb_evt_if #(
    parameter int CH_W = 2
);
    logic            evt_valid_o;
    logic            evt_ready_i;
    logic [CH_W-1:0] evt_ch_o;
    logic            evt_type_o;

    modport master (output evt_valid_o, evt_ch_o, evt_type_o, input evt_ready_i);
    modport slave  (input evt_valid_o, evt_ch_o, evt_type_o, output evt_ready_i);
endinterface

// File: rtl/hb_rr_arb.sv
// Round-robin arbiter over pending channels. A presented grant is held until
// accepted (or its request vanishes); the search pointer moves only on accept.
module hb_rr_arb
    import hb_pkg::*;
#(
    parameter  int N = 4,
    localparam int W = ch_width(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx,
    output logic         valid
);

    logic [W-1:0] ptr_q;
    logic         hold_q;
    logic [N-1:0] hold_gnt_q;
    logic [W-1:0] hold_idx_q;
    logic [N-1:0] rr_gnt;
    logic [W-1:0] rr_idx;
    logic         found;
    int           j;

    always_comb begin
        rr_gnt = '0;
        rr_idx = '0;
        found  = 1'b0;
        j      = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr_q) + i) % N;
            if (!found && req[j]) begin
                found     = 1'b1;
                rr_gnt[j] = 1'b1;
                rr_idx    = W'(j);
            end
        end
    end

    // Keep the presented channel stable while the consumer stalls, even if a
    // channel earlier in search order becomes pending meanwhile.
    always_comb begin
        valid = |req;
        if (hold_q && |(hold_gnt_q & req)) begin
            gnt     = hold_gnt_q;
            gnt_idx = hold_idx_q;
        end else begin
            gnt     = rr_gnt;
            gnt_idx = rr_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            hold_q     <= 1'b0;
            hold_gnt_q <= '0;
            hold_idx_q <= '0;
        end else if (accept) begin
            ptr_q  <= (gnt_idx == W'(N - 1)) ? '0 : gnt_idx + W'(1);
            hold_q <= 1'b0;
        end else begin
            hold_q     <= valid;
            hold_gnt_q <= gnt;
            hold_idx_q <= gnt_idx;
        end
    end

endmodule

// File: rtl/hb_monitor.sv
// Per-channel heartbeat session monitor with round-robin event reporting.
// Define HB_MON_TESTREQ_EN for the two-stage ARMED->TESTREQ->IDLE expiry path.
module hb_monitor
    import hb_pkg::*;
#(
    parameter  int NUM_CH           = 4,
    parameter  int HB_RANGE         = HB_RANGE_DEF,
    parameter  int DEFAULT_INTERVAL = 100,
    localparam int CH_W             = ch_width(NUM_CH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_CH-1:0]   start_i,
    input  logic [NUM_CH-1:0]   stop_i,
    input  logic [NUM_CH-1:0]   msg_rx_i,
    input  logic                cfg_we_i,
    input  logic [CH_W-1:0]     cfg_ch_i,
    input  logic [HB_RANGE-1:0] cfg_interval_i,
    output logic [NUM_CH-1:0]   active_o,
    output logic [NUM_CH-1:0]   ovf_o,
    hb_evt_if.master            evt
);

    logic [NUM_CH-1:0] pend_vec;
    logic [NUM_CH-1:0] ptype_vec;
    logic [NUM_CH-1:0] gnt;
    logic [NUM_CH-1:0] take;
    logic [CH_W-1:0]   gnt_idx;
    logic              arb_valid;
    logic              accept;

    assign accept = arb_valid & evt.evt_ready_i;
    assign take   = accept ? gnt : '0;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        hb_state_e           state_q, state_d;
        logic [HB_RANGE-1:0] count_q, count_d, interval_q;
        logic                pend_q, ovf_q, post, expire;
        hb_evt_e             ptype_q, post_type;

        assign expire = (state_q != ST_IDLE) && (count_q == interval_q);

        always_comb begin
            state_d   = state_q;
            count_d   = count_q;
            post      = 1'b0;
            post_type = EVT_TIMEOUT;
            if (stop_i[c]) begin
                state_d = ST_IDLE;
                count_d = '0;
            end else if (state_q == ST_IDLE) begin
                if (start_i[c] && interval_q != '0) begin
                    state_d = ST_ARMED;
                    count_d = '0;
                end
            end else if (msg_rx_i[c] || start_i[c]) begin
                state_d = ST_ARMED;
                count_d = '0;
            end else if (expire) begin
                post    = 1'b1;
                count_d = '0;
`ifdef HB_MON_TESTREQ_EN
                if (state_q == ST_ARMED) begin
                    state_d   = ST_TESTREQ;
                    post_type = EVT_TEST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end else begin
                count_d = count_q + HB_RANGE'(1);
            end
        end

        // A new post wins over a same-cycle accept; it only counts as an
        // overwrite if the older event was not taken in that cycle.
        always_ff @(posedge clk) begin
            if (rst) begin
                state_q    <= ST_IDLE;
                count_q    <= '0;
                interval_q <= HB_RANGE'(DEFAULT_INTERVAL);
                pend_q     <= 1'b0;
                ptype_q    <= EVT_TEST_REQ;
                ovf_q      <= 1'b0;
            end else begin
                state_q <= state_d;
                count_q <= count_d;
                if (cfg_we_i && cfg_ch_i == CH_W'(c))
                    interval_q <= cfg_interval_i;
                if (stop_i[c]) begin
                    pend_q <= 1'b0;
                end else if (post) begin
                    pend_q  <= 1'b1;
                    ptype_q <= post_type;
                    if (pend_q && !take[c])
                        ovf_q <= 1'b1;
                end else if (take[c]) begin
                    pend_q <= 1'b0;
                end
            end
        end

        assign pend_vec[c]  = pend_q;
        assign ptype_vec[c] = ptype_q;
        assign ovf_o[c]     = ovf_q;
        assign active_o[c]  = (state_q != ST_IDLE);
    end

    hb_rr_arb #(.N(NUM_CH)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (pend_vec),
        .accept  (accept),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .valid   (arb_valid)
    );

    assign evt.evt_valid_o = arb_valid;
    assign evt.evt_ch_o    = gnt_idx;
    assign evt.evt_type_o  = |(gnt & ptype_vec);

endmodule

// File: tb/tb_hb_monitor.sv
// Directed bench for hb_monitor; expectations follow whichever expiry mode
// (single- or two-stage) the build selects.
module tb_hb_monitor;
    import hb_pkg::*;

    localparam int NUM_CH   = 4;
    localparam int HB_RANGE = 16;
    localparam int CH_W     = 2;

`ifdef HB_MON_TESTREQ_EN
    localparam hb_evt_e FIRST_EVT = EVT_TEST_REQ;
`else
    localparam hb_evt_e FIRST_EVT = EVT_TIMEOUT;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NUM_CH-1:0]   start = '0, stop = '0, msg = '0;
    logic                cfg_we = 1'b0;
    logic [CH_W-1:0]     cfg_ch = '0;
    logic [HB_RANGE-1:0] cfg_int = '0;
    logic [NUM_CH-1:0]   active, ovf;
    int                  vecs = 0, errs = 0;

    hb_evt_if #(.CH_W(CH_W)) evt ();

    hb_monitor #(.NUM_CH(NUM_CH), .HB_RANGE(HB_RANGE), .DEFAULT_INTERVAL(100)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .stop_i         (stop),
        .msg_rx_i       (msg),
        .cfg_we_i       (cfg_we),
        .cfg_ch_i       (cfg_ch),
        .cfg_interval_i (cfg_int),
        .active_o       (active),
        .ovf_o          (ovf),
        .evt            (evt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp)
        else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_evt(input string tag, input logic v, input logic [CH_W-1:0] ch, input logic t);
        chk({tag, "_valid"}, 32'(evt.evt_valid_o), 32'(v));
        if (v) begin
            chk({tag, "_ch"}, 32'(evt.evt_ch_o), 32'(ch));
            chk({tag, "_type"}, 32'(evt.evt_type_o), 32'(t));
        end
    endtask

    task automatic cfg(input logic [CH_W-1:0] c, input logic [HB_RANGE-1:0] v);
        cfg_we = 1'b1; cfg_ch = c; cfg_int = v;
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        int bad;
        evt.evt_ready_i = 1'b1;

        // reset, with a start request that must be overridden
        rst = 1'b1; start = 4'h1;
        tick(2);
        chk("rst_active", active, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_valid", evt.evt_valid_o, 0);
        chk("rst_ch", evt.evt_ch_o, 0);
        chk("rst_type", evt.evt_type_o, 0);
        rst = 1'b0; start = '0;

        // A: interval 5, ch0 armed at cycle 0, no traffic
        cfg(0, 5);
        start[0] = 1'b1; tick(); start[0] = 1'b0;            // cycle 1
        chk("a_armed", active[0], 1);
        tick(5);                                              // cycle 6
        chk_evt("a_c6", 0, 0, 0);
        tick();                                               // cycle 7
`ifdef HB_MON_TESTREQ_EN
        chk_evt("a_treq", 1, 0, EVT_TEST_REQ);
        chk("a_c7_active", active[0], 1);
        tick();                                               // cycle 8
        chk_evt("a_c8", 0, 0, 0);
        tick(4);                                              // cycle 12
        chk_evt("a_c12", 0, 0, 0);
        tick();                                               // cycle 13
        chk_evt("a_tmo", 1, 0, EVT_TIMEOUT);
        chk("a_c13_active", active[0], 0);
`else
        chk_evt("a_tmo", 1, 0, EVT_TIMEOUT);
        chk("a_c7_active", active[0], 0);
`endif
        tick();
        chk_evt("a_done", 0, 0, 0);

        // B: msg every 4 cycles keeps ch0 alive
        bad = 0;
        start[0] = 1'b1; tick(); start[0] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            msg[0] = (i % 4 == 3);
            if (evt.evt_valid_o) bad++;
            tick();
        end
        msg = '0;
        chk("b_no_evt", bad, 0);
        chk("b_active", active[0], 1);
        stop[0] = 1'b1; tick(); stop[0] = 1'b0;
        chk("b_stopped", active[0], 0);

        // C: ch1 and ch2 expire together while the consumer stalls
        cfg(1, 8); cfg(2, 8);
        evt.evt_ready_i = 1'b0;
        start = 4'b0110; tick(); start = '0;                  // cycle 1
        tick(8);                                              // cycle 9
        chk_evt("c_c9", 0, 0, 0);
        tick();                                               // cycle 10
        chk_evt("c_c10", 1, 1, FIRST_EVT);
        tick();
        chk_evt("c_c11", 1, 1, FIRST_EVT);
        tick();
        chk_evt("c_c12", 1, 1, FIRST_EVT);
        tick(); evt.evt_ready_i = 1'b1;                       // cycle 13
        chk_evt("c_c13", 1, 1, FIRST_EVT);
        tick();                                               // cycle 14
        chk_evt("c_ch2", 1, 2, FIRST_EVT);
        tick();                                               // cycle 15
        chk_evt("c_drained", 0, 0, 0);
        chk("c_ovf", ovf, 0);
        stop = 4'b0110; tick(); stop = '0;
        chk("c_idle", active, 0);

        // D: stop and msg together with expiry on ch3
        cfg(3, 4);
        start[3] = 1'b1; tick(); start[3] = 1'b0;             // cycle 1
        tick(4);                                              // cycle 5: count==4
        stop[3] = 1'b1; msg[3] = 1'b1; tick(); stop = '0; msg = '0;
        chk_evt("d_c6", 0, 0, 0);
        chk("d_idle", active[3], 0);
        tick();
        chk_evt("d_c7", 0, 0, 0);
        chk("d_ovf", ovf[3], 0);
        start[3] = 1'b1; tick(); start[3] = 1'b0;
        tick(4);                                              // expiry cycle
        msg[3] = 1'b1; tick(); msg = '0;
        chk("d_msg_keeps_armed", active[3], 1);
        chk_evt("d_msg_no_evt", 0, 0, 0);
        stop[3] = 1'b1; tick(); stop = '0;

        // E: consumer stalled, ch0 posts twice -> overwrite
        evt.evt_ready_i = 1'b0;
        start[0] = 1'b1; tick(); start[0] = 1'b0;             // cycle 1
        tick(6);                                              // cycle 7
`ifdef HB_MON_TESTREQ_EN
        chk_evt("e_treq", 1, 0, EVT_TEST_REQ);
        chk("e_ovf_clear", ovf[0], 0);
        tick(6);                                              // cycle 13
        chk("e_active", active[0], 0);
`else
        chk_evt("e_tmo1", 1, 0, EVT_TIMEOUT);
        chk("e_ovf_clear", ovf[0], 0);
        chk("e_active", active[0], 0);
        start[0] = 1'b1; tick(); start[0] = 1'b0;             // cycle 8
        tick(6);                                              // cycle 14
`endif
        chk_evt("e_tmo", 1, 0, EVT_TIMEOUT);
        chk("e_ovf_set", ovf[0], 1);
        evt.evt_ready_i = 1'b1;
        tick();
        chk_evt("e_single", 0, 0, 0);
        chk("e_ovf_sticky", ovf[0], 1);

        // F: zero interval ignores start; reset mid-count clears everything
        cfg(1, 0);
        start[1] = 1'b1; tick(); start[1] = 1'b0;
        chk("f_zero_idle", active[1], 0);
        tick();
        chk("f_zero_idle2", active[1], 0);
        evt.evt_ready_i = 1'b0;
        start[0] = 1'b1; tick(); start[0] = 1'b0;             // cycle 1
        tick(6);                                              // cycle 7
        chk_evt("f_pending", 1, 0, FIRST_EVT);
        rst = 1'b1; start = '1; msg = '1; cfg_we = 1'b1; cfg_ch = 0; cfg_int = 3;
        tick();
        rst = 1'b0; start = '0; msg = '0; cfg_we = 1'b0;
        chk("f_rst_active", active, 0);
        chk("f_rst_ovf", ovf, 0);
        chk("f_rst_valid", evt.evt_valid_o, 0);
        chk("f_rst_ch", evt.evt_ch_o, 0);
        chk("f_rst_type", evt.evt_type_o, 0);
        // interval back at 100 after reset
        start[0] = 1'b1; tick(); start[0] = 1'b0;             // cycle 1
        tick(100);                                            // cycle 101
        chk_evt("f_def_c101", 0, 0, 0);
        tick();                                               // cycle 102
        chk_evt("f_def_c102", 1, 0, FIRST_EVT);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
